// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM state type for the 16:1 mux scan sequencer.
package mux_scan_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WRAP = 2'd2
  } state_e;
endpackage

// File: rtl/mux_scan_dwell_timer.sv
// Dwell down-counter: load restarts the count at DWELL-1, enable counts down,
// tc is high on the last dwell cycle of the current channel.
module mux_scan_dwell_timer #(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a 16:1 mux channel by channel and emits one 16-bit frame per pass on valid/ready.
// Optional SCAN_PARITY_EN adds frame_parity (= ^frame_data), registered alongside frame_data.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  select,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic              overrun,
`ifdef SCAN_PARITY_EN
  output logic              frame_parity,
`endif
  output state_e            state_dbg_o
);
  // Handshake: a frame transfers on any rising edge where frame_valid & frame_ready;
  // frame_valid/frame_data never change while frame_valid & !frame_ready.
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  select_q, select_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overrun_q, overrun_d;
  logic              parity_q, parity_d;
  logic              timer_load, timer_en, timer_tc;
  logic              chan_en, chan_done;

  mux_scan_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .en_i   (timer_en),
    .tc_o   (timer_tc)
  );

  assign chan_en   = mask_q[ch_q];
  // Masked channels occupy exactly one cycle regardless of DWELL.
  assign chan_done = !chan_en || timer_tc;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    select_d      = select_q;
    mask_d        = mask_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    parity_d      = parity_q;
    overrun_d     = 1'b0;
    timer_load    = 1'b0;
    timer_en      = 1'b0;

    if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          mask_d     = ch_mask;
          ch_d       = '0;
          select_d   = '0;
          timer_load = 1'b1;
        end
      end
      SCAN: begin
        timer_en = 1'b1;
        if (chan_done) begin
          shadow_d[ch_q] = chan_en & mux_out;
          timer_load     = 1'b1;
          if (ch_q == SEL_W'(NUM_CH - 1)) begin
            state_d  = WRAP;
            ch_d     = '0;
            select_d = '0;
          end else begin
            ch_d     = ch_q + 1'b1;
            select_d = ch_q + 1'b1;
          end
        end
      end
      WRAP: begin
        // A frame still waiting for the consumer wins; the new one is dropped.
        if (!frame_valid_q || frame_ready) begin
          frame_data_d  = shadow_q;
          frame_valid_d = 1'b1;
          parity_d      = ^shadow_q;
        end else begin
          overrun_d = 1'b1;
        end
        select_d = '0;
        ch_d     = '0;
        if (continuous) begin
          state_d    = SCAN;
          mask_d     = ch_mask;
          timer_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      select_q      <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      parity_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      select_q      <= select_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      parity_q      <= parity_d;
    end
  end

  assign select      = select_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg_o = state_q;
`ifdef SCAN_PARITY_EN
  assign frame_parity = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif
endmodule
